gen_down_timer: RTL and testbench

Loadable, prescaled down-counting timer. It is the countdown counterpart of the team's generic up-counter.
- Loads a start value, decrements once per prescaler tick while enabled, and flags expiry at zero.
- Supports one-shot or auto-reload operation.
- Used for power-sequencing timeouts, watchdogs and periodic tick generation in the CPLD.

---
 rtl/gen_timer_pkg.sv | 23 ++
 rtl/gen_prescaler.sv | 38 +++
 rtl/gen_down_timer.sv | 122 ++++++++++++
 tb/tb_gen_down_timer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gen_timer_pkg.sv
// Shared definitions for the generic timer family: width helper and FSM state encoding.
package gen_timer_pkg;

  // floor(log2(x)); returns 0 for x <= 1
  function automatic int logb2(input int x);
    int v;
    int r;
    v = x;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } timer_state_t;

endpackage

// File: rtl/gen_prescaler.sv
// Down-counting prescaler producing one tick every PRESCALE enabled clocks.
module gen_prescaler
  import gen_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClear,
  input  logic iRestart,
  input  logic iEn,
  output logic oTick
);

  localparam int PW = logb2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_RLD = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          w_zero;

  assign w_zero = (r_cnt == '0);
  // With PRESCALE=1 the count is pinned at 0, so the tick simply follows iEn.
  assign oTick  = iEn && w_zero;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt <= '0;
    end else if (iClear) begin
      r_cnt <= '0;
    end else if (iRestart) begin
      r_cnt <= PRE_RLD;
    end else if (iEn) begin
      if (w_zero) r_cnt <= PRE_RLD;
      else        r_cnt <= r_cnt - PW'(1);
    end
  end

endmodule

// File: rtl/gen_down_timer.sv
// Loadable prescaled down-counter with one-shot / auto-reload expiry and sticky flag.
module gen_down_timer
  import gen_timer_pkg::*;
#(
  parameter int MAX_LOAD = 1000,
  parameter int PRESCALE = 1,
  localparam int W = logb2(MAX_LOAD) + 1
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  input  logic         iAutoReload,
  input  logic         iCntEn,
  input  logic         iAbort,
  input  logic         iClrExp,
  output logic [W-1:0] oCntr,
  output logic         oRunning,
  output logic         oExpPulse,
  output logic         oExpired
);

  localparam logic [W-1:0] MAX_W = W'(MAX_LOAD);

  function automatic logic [W-1:0] f_sat(input logic [W-1:0] val);
    return (val > MAX_W) ? MAX_W : val;
  endfunction

  timer_state_t r_state;
  logic [W-1:0] r_cntr;
  logic [W-1:0] r_reload;
  logic         r_auto;
  logic         r_running;
  logic         r_exp_pulse;
  logic         r_expired;

  logic [W-1:0] w_sat;
  logic         w_pre_en;
  logic         w_tick;

  assign w_sat    = f_sat(iLoadVal);
  assign w_pre_en = (r_state == ST_RUN) && iCntEn && !iAbort && !iLoad;

  gen_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iClear   (iAbort),
    .iRestart (iLoad && !iAbort),
    .iEn      (w_pre_en),
    .oTick    (w_tick)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state     <= ST_IDLE;
      r_cntr      <= '0;
      r_reload    <= '0;
      r_auto      <= 1'b0;
      r_running   <= 1'b0;
      r_exp_pulse <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_exp_pulse <= 1'b0;
      // Clear is applied first so any expiry below in the same cycle overrides it.
      if (iClrExp) r_expired <= 1'b0;

      if (iAbort) begin
        r_state   <= ST_IDLE;
        r_cntr    <= '0;
        r_running <= 1'b0;
      end else if (iLoad) begin
        r_cntr   <= w_sat;
        r_reload <= w_sat;
        r_auto   <= iAutoReload;
        if (w_sat == '0) begin
          r_state     <= ST_EXPIRED;
          r_running   <= 1'b0;
          r_exp_pulse <= 1'b1;
          r_expired   <= 1'b1;
        end else begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_tick) begin
              if (r_cntr > W'(1)) begin
                r_cntr <= r_cntr - W'(1);
              end else begin
                r_exp_pulse <= 1'b1;
                r_expired   <= 1'b1;
                if (r_auto) begin
                  r_cntr <= r_reload;
                end else begin
                  r_cntr    <= '0;
                  r_state   <= ST_EXPIRED;
                  r_running <= 1'b0;
                end
              end
            end
          end
          ST_IDLE, ST_EXPIRED: begin
            r_state <= r_state;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oCntr     = r_cntr;
  assign oRunning  = r_running;
  assign oExpPulse = r_exp_pulse;
  assign oExpired  = r_expired;

endmodule

// File: tb/tb_gen_down_timer.sv
// Directed bench for gen_down_timer with MAX_LOAD=10, PRESCALE=2.
module tb_gen_down_timer;

  localparam int W = 4;

  logic         iClk;
  logic         iRst_n;
  logic         iLoad;
  logic [W-1:0] iLoadVal;
  logic         iAutoReload;
  logic         iCntEn;
  logic         iAbort;
  logic         iClrExp;
  logic [W-1:0] oCntr;
  logic         oRunning;
  logic         oExpPulse;
  logic         oExpired;

  int n_chk;
  int n_err;

  gen_down_timer #(
    .MAX_LOAD (10),
    .PRESCALE (2)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iLoad       (iLoad),
    .iLoadVal    (iLoadVal),
    .iAutoReload (iAutoReload),
    .iCntEn      (iCntEn),
    .iAbort      (iAbort),
    .iClrExp     (iClrExp),
    .oCntr       (oCntr),
    .oRunning    (oRunning),
    .oExpPulse   (oExpPulse),
    .oExpired    (oExpired)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic load(input int val, input logic auto_rl);
    iLoad       = 1'b1;
    iLoadVal    = W'(val);
    iAutoReload = auto_rl;
    step();
    iLoad       = 1'b0;
  endtask

  task automatic clear_exp();
    iClrExp = 1'b1;
    step();
    iClrExp = 1'b0;
  endtask

  int os_cnt[7]  = '{3, 3, 2, 2, 1, 1, 0};
  int ar_cnt[11] = '{2, 2, 1, 1, 2, 2, 1, 1, 2, 2, 1};
  int en_cnt[18] = '{5, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0};

  initial begin
    n_chk       = 0;
    n_err       = 0;
    iRst_n      = 1'b0;
    iLoad       = 1'b0;
    iLoadVal    = '0;
    iAutoReload = 1'b0;
    iCntEn      = 1'b1;
    iAbort      = 1'b0;
    iClrExp     = 1'b0;
    step();
    step();
    chk("rst_cntr", oCntr, 0);
    chk("rst_running", oRunning, 0);
    chk("rst_pulse", oExpPulse, 0);
    chk("rst_expired", oExpired, 0);
    iRst_n = 1'b1;
    step();

    // One-shot load 3: expiry 6 clocks after load
    load(3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      chk($sformatf("os_cntr[%0d]", i), oCntr, os_cnt[i]);
      chk($sformatf("os_pulse[%0d]", i), oExpPulse, (i == 6) ? 1 : 0);
    end
    chk("os_expired", oExpired, 1);
    chk("os_running", oRunning, 0);
    step();
    chk("os_hold_cntr", oCntr, 0);
    chk("os_hold_pulse", oExpPulse, 0);
    chk("os_hold_expired", oExpired, 1);
    clear_exp();
    chk("clr_expired", oExpired, 0);

    // Auto-reload load 2: pulse every 4th cycle with reload to 2
    load(2, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      chk($sformatf("ar_cntr[%0d]", i), oCntr, ar_cnt[i]);
      chk($sformatf("ar_pulse[%0d]", i), oExpPulse, (i == 4 || i == 8) ? 1 : 0);
      chk($sformatf("ar_running[%0d]", i), oRunning, 1);
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    chk("ab_cntr", oCntr, 0);
    chk("ab_running", oRunning, 0);
    chk("ab_pulse", oExpPulse, 0);
    chk("ab_expired_kept", oExpired, 1);
    clear_exp();

    // Load 5 with enable dropped for 7 edges: expiry at 17
    load(5, 1'b0);
    chk("en_cntr[0]", oCntr, 5);
    for (int k = 1; k < 18; k++) begin
      iCntEn = !(k >= 4 && k <= 10);
      step();
      chk($sformatf("en_cntr[%0d]", k), oCntr, en_cnt[k]);
      chk($sformatf("en_pulse[%0d]", k), oExpPulse, (k == 17) ? 1 : 0);
    end
    iCntEn = 1'b1;
    clear_exp();

    // Saturation and zero load
    load(15, 1'b0);
    chk("sat_cntr", oCntr, 10);
    chk("sat_running", oRunning, 1);
    load(0, 1'b1);
    chk("zero_cntr", oCntr, 0);
    chk("zero_pulse", oExpPulse, 1);
    chk("zero_expired", oExpired, 1);
    chk("zero_running", oRunning, 0);
    step();
    chk("zero_pulse_end", oExpPulse, 0);
    clear_exp();

    // Abort beats load at count 4
    load(6, 1'b0);
    repeat (4) step();
    chk("pri_cntr4", oCntr, 4);
    iAbort   = 1'b1;
    iLoad    = 1'b1;
    iLoadVal = W'(7);
    step();
    iAbort   = 1'b0;
    iLoad    = 1'b0;
    chk("pri_cntr", oCntr, 0);
    chk("pri_running", oRunning, 0);
    chk("pri_pulse", oExpPulse, 0);

    // Reload at count 4 with prescaler at 0 must restart the prescaler
    load(6, 1'b0);
    repeat (5) step();
    chk("rl_cntr4", oCntr, 4);
    load(3, 1'b0);
    chk("rl_cntr_a", oCntr, 3);
    step();
    chk("rl_cntr_b", oCntr, 3);
    step();
    chk("rl_cntr_c", oCntr, 2);

    // Expiry wins over clear in the same cycle
    load(1, 1'b0);
    step();
    iClrExp = 1'b1;
    step();
    chk("ce_pulse", oExpPulse, 1);
    chk("ce_expired_set", oExpired, 1);
    step();
    iClrExp = 1'b0;
    chk("ce_expired_clr", oExpired, 0);

    // Asynchronous reset mid-count
    load(1, 1'b1);
    repeat (3) step();
    chk("ar1_expired", oExpired, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_cntr", oCntr, 0);
    chk("arst_running", oRunning, 0);
    chk("arst_pulse", oExpPulse, 0);
    chk("arst_expired", oExpired, 0);
    step();
    iRst_n = 1'b1;
    step();
    chk("post_rst_cntr", oCntr, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
